grid_palette_loader: RTL and testbench
======================================

Name: grid_palette_loader

Overview:
- Upstream feeder for the 800x600 colour-grid display stage. Replaces its fixed colour ROM with a host-loadable 64-entry palette.
- Accepts a byte stream (valid/ready, e.g. from a UART receiver) carrying write and commit commands. Writes land in a shadow bank.
- A commit copies the shadow bank to the active bank only at the next vsync falling edge, so the display never tears mid-frame.
- The active bank is read by the display stage through a ROM-compatible port with 1-cycle latency.

Parameters:
- HDR_WRITE, 8'hA5, header byte opening a 3-byte write command.
- HDR_COMMIT, 8'h5A, single-byte commit command.
- ERR_W, 8, width of the saturating protocol-error counter.

Ports:
- clk  in  1  system clock; same domain as the display timing stage.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- vsync  in  1  active-low vertical sync from the timing stage.
- rd_addr  in  6  palette read address {row[2:0], col[2:0]}.
- rd_data  out  8  colour {R[1:0], G[2:0], B[2:0]}, registered.
- commit_pending  out  1  a commit is waiting for the frame boundary.
- swap_done  out  1  one-cycle pulse when the active bank is updated.
- err_cnt  out  ERR_W  saturating count of rejected bytes.

Behaviour:
- Reset is asynchronous and active-low. It clears:
  - both banks (all 64 entries) to 8'h00;
  - rd_data to 0 and err_cnt to 0;
  - state to IDLE, with commit_pending=0 and swap_done=0;
  - vsync_d to 0, so no spurious edge is seen after reset.
- Reset mid-command discards any partial command and any pending commit.
- Byte transfer occurs when in_valid && in_ready. in_ready is 1 in IDLE, GET_ADDR and GET_DATA, and 0 in WAIT_SWAP.
- FSM states: IDLE, GET_ADDR, GET_DATA, WAIT_SWAP.
- IDLE:
  - byte == HDR_WRITE -> GET_ADDR.
  - byte == HDR_COMMIT -> WAIT_SWAP.
  - any other byte -> err_cnt+1, stay in IDLE.
- GET_ADDR:
  - byte[7:6] == 2'b00 -> latch addr = byte[5:0], go to GET_DATA.
  - otherwise -> err_cnt+1, go to IDLE.
- GET_DATA: shadow[addr] <= byte on the transfer cycle, then go to IDLE. There is no error case.
- WAIT_SWAP:
  - commit_pending = 1.
  - On a vsync falling edge (vsync_d==1 && vsync==0): all 64 active entries <= shadow in one cycle, swap_done pulses high for that same cycle, go to IDLE.
- Edge timing: the edge is only consumed while in WAIT_SWAP. An edge in the same cycle the commit byte is accepted is ignored; the swap waits for the next frame.
- Shadow contents persist after a commit. Subsequent writes modify only the shadow.
- Read port: rd_data <= active[rd_addr] every cycle (1-cycle latency, matching the ROM timing). On the copy cycle, rd_data takes the pre-copy value. The new value is visible from the following cycle's read.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- in_valid without in_ready stalls the byte: nothing is consumed and err_cnt does not change.

Decomposition:
- Shared package vga_pkg holds:
  - HDR_WRITE and HDR_COMMIT;
  - the colour bit-field positions (R=7:6, G=5:3, B=2:0);
  - the palette depth of 64 and address width of 6;
  - the FSM state enum.
- One natural sub-module, vsync_edge_det: registers vsync and produces the falling-edge pulse.
- The banks and the FSM stay inline.

Test Plan:
- Write: send A5,09,E0 then 5A; drive vsync 1->0 -> swap_done pulses once, commit_pending falls. A read of rd_addr=9 returns 8'hE0 one cycle later; rd_addr=0 returns 8'h00.
- Tear-free: write entry 9=1C and commit with vsync held high for 1000 cycles -> rd_data for addr 9 stays at the old value and in_ready=0 throughout. After the falling edge, it reads 8'h1C.
- Bad address: send A5,47 -> err_cnt=1, FSM back in IDLE. A following A5,01,FF,5A plus a vsync edge -> addr 1 reads FF.
- Same-cycle edge: commit byte accepted in the same cycle as a vsync falling edge -> no swap. The swap occurs at the next edge only.
- Saturation: send 300 bytes of 8'h00 -> err_cnt = 255.
- Reset mid-command: send A5,05 then assert rst_n=0 -> all reads return 00 and err_cnt=0. Next send 01 -> counted as an error (FSM in IDLE).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the colour-grid display path: command bytes,
// colour field layout, palette geometry and the loader FSM states.
package vga_pkg;

    localparam logic [7:0] HDR_WRITE  = 8'hA5;
    localparam logic [7:0] HDR_COMMIT = 8'h5A;

    // Colour byte layout {R[1:0], G[2:0], B[2:0]}
    localparam int R_MSB = 7;
    localparam int R_LSB = 6;
    localparam int G_MSB = 5;
    localparam int G_LSB = 3;
    localparam int B_MSB = 2;
    localparam int B_LSB = 0;

    localparam int PAL_DEPTH = 64;
    localparam int PAL_AW    = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GET_ADDR  = 2'd1,
        ST_GET_DATA  = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_e;

endpackage

// File: rtl/vsync_edge_det.sv
// Registers the active-low vsync and flags its falling edge (frame start).
module vsync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic vsync_fall
);

    logic vsync_q;

    // Resets low so a vsync already high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign vsync_fall = vsync_q && !vsync;

endmodule

// File: rtl/grid_palette_loader.sv
// Host-loadable 64-entry palette: byte commands fill a shadow bank, and a
// commit copies it to the display-visible active bank at the next frame start.
module grid_palette_loader
    import vga_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             vsync,
    input  logic [5:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             commit_pending,
    output logic             swap_done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: a byte moves only on a cycle where in_valid && in_ready.
    state_e              state_q, state_d;
    logic [PAL_AW-1:0]   addr_q, addr_d;
    logic [7:0]          shadow_q [PAL_DEPTH];
    logic [7:0]          active_q [PAL_DEPTH];
    logic [7:0]          rd_data_q;
    logic [ERR_W-1:0]    err_q;
    logic                xfer;
    logic                vsync_fall;
    logic                err_inc;
    logic                shadow_we;
    logic                do_swap;

    vsync_edge_det u_vsync_edge_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .vsync_fall (vsync_fall)
    );

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        err_inc        = 1'b0;
        shadow_we      = 1'b0;
        do_swap        = 1'b0;
        in_ready       = 1'b1;
        commit_pending = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (in_data == HDR_WRITE) begin
                        state_d = ST_GET_ADDR;
                    end else if (in_data == HDR_COMMIT) begin
                        state_d = ST_WAIT_SWAP;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (xfer) begin
                    if (in_data[7:6] == 2'b00) begin
                        addr_d  = in_data[PAL_AW-1:0];
                        state_d = ST_GET_DATA;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GET_DATA: begin
                if (xfer) begin
                    shadow_we = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_SWAP: begin
                // Host is held off until the copy lands, so commits never stack.
                in_ready       = 1'b0;
                commit_pending = 1'b1;
                if (vsync_fall) begin
                    do_swap = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (shadow_we) begin
            shadow_q[addr_q] <= in_data;
        end
    end

    // Whole-bank copy in one cycle; the read below still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                active_q[i] <= 8'h00;
            end
        end else if (do_swap) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= active_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign rd_data   = rd_data_q;
    assign err_cnt   = err_q;
    assign swap_done = do_swap;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_grid_palette_loader.sv
// Directed bench for grid_palette_loader: command stream vectors, swap timing,
// tear-free hold, same-cycle edge, error saturation and mid-command reset.
module tb_grid_palette_loader;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       vsync;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       commit_pending;
    logic       swap_done;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    int total;
    int bad;
    int exp_err;

    typedef struct {
        logic [7:0] b;
        logic [1:0] exp_state;
        logic       is_err;
    } byte_vec_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    byte_vec_t stream_tbl[8];
    rd_vec_t   pal_tbl[5];
    rd_vec_t   rst_tbl[5];

    grid_palette_loader #(.ERR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .vsync          (vsync),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .commit_pending (commit_pending),
        .swap_done      (swap_done),
        .err_cnt        (err_cnt),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void note_err();
        if (exp_err < 255) exp_err++;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        chk("in_ready_before_send", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_read(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1;
        chk("rd_data", rd_data, exp);
    endtask

    // rd_addr must already select the entry of interest; vsync must be high.
    task automatic do_swap(input logic [7:0] old_val, input logic [7:0] new_val);
        @(negedge clk);
        vsync = 1'b0;
        #1;
        chk("swap_done_on_edge", swap_done, 1'b1);
        chk("commit_pending_on_edge", commit_pending, 1'b1);
        @(posedge clk);
        #1;
        chk("swap_done_after", swap_done, 1'b0);
        chk("commit_pending_after", commit_pending, 1'b0);
        chk("state_after_swap", dbg_state, S_IDLE);
        chk("rd_data_copy_cycle", rd_data, old_val);
        @(posedge clk);
        #1;
        chk("rd_data_post_copy", rd_data, new_val);
        @(negedge clk);
        vsync = 1'b1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_err  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        vsync    = 1'b1;
        rd_addr  = 6'd0;

        stream_tbl[0] = '{8'h00, S_IDLE, 1'b1};
        stream_tbl[1] = '{8'hA5, S_ADDR, 1'b0};
        stream_tbl[2] = '{8'h3F, S_DATA, 1'b0};
        stream_tbl[3] = '{8'h77, S_IDLE, 1'b0};
        stream_tbl[4] = '{8'hA5, S_ADDR, 1'b0};
        stream_tbl[5] = '{8'h80, S_IDLE, 1'b1};
        stream_tbl[6] = '{8'hFF, S_IDLE, 1'b1};
        stream_tbl[7] = '{8'h5A, S_WAIT, 1'b0};

        pal_tbl[0] = '{6'd9,  8'hAA};
        pal_tbl[1] = '{6'd1,  8'hFF};
        pal_tbl[2] = '{6'h3F, 8'h77};
        pal_tbl[3] = '{6'd0,  8'h00};
        pal_tbl[4] = '{6'd5,  8'h00};

        rst_tbl[0] = '{6'd9,  8'h00};
        rst_tbl[1] = '{6'd1,  8'h00};
        rst_tbl[2] = '{6'h3F, 8'h00};
        rst_tbl[3] = '{6'd5,  8'h00};
        rst_tbl[4] = '{6'd0,  8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_err_cnt", err_cnt, 8'h00);
        chk("reset_state", dbg_state, S_IDLE);
        chk("reset_commit_pending", commit_pending, 1'b0);
        chk("reset_swap_done", swap_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("no_spurious_swap", swap_done, 1'b0);

        // Basic write and commit
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'hE0);
        send_byte(8'h5A);
        chk("commit_pending_set", commit_pending, 1'b1);
        chk("wait_in_ready", in_ready, 1'b0);
        rd_addr = 6'd9;
        do_swap(8'h00, 8'hE0);
        check_read(6'd0, 8'h00);
        check_read(6'd9, 8'hE0);

        // Tear-free: vsync held high with a stalled byte offered throughout
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'h1C);
        send_byte(8'h5A);
        @(negedge clk);
        rd_addr  = 6'd9;
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("tear_rd_data", rd_data, 8'hE0);
            chk("tear_in_ready", in_ready, 1'b0);
            chk("tear_err_stall", err_cnt, exp_err);
        end
        in_valid = 1'b0;
        chk("tear_state", dbg_state, S_WAIT);
        do_swap(8'hE0, 8'h1C);

        // Bad address byte
        send_byte(8'hA5);
        send_byte(8'h47);
        note_err();
        @(negedge clk);
        chk("badaddr_err_cnt", err_cnt, exp_err);
        chk("badaddr_state", dbg_state, S_IDLE);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h5A);
        rd_addr = 6'd1;
        do_swap(8'h00, 8'hFF);

        // Table-driven command stream
        for (int i = 0; i < 8; i++) begin
            send_byte(stream_tbl[i].b);
            if (stream_tbl[i].is_err) note_err();
            chk("stream_state", dbg_state, stream_tbl[i].exp_state);
            chk("stream_err_cnt", err_cnt, exp_err);
        end
        rd_addr = 6'h3F;
        do_swap(8'h00, 8'h77);

        // Commit accepted on the same cycle as a vsync falling edge
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'hAA);
        @(negedge clk);
        rd_addr  = 6'd9;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        vsync    = 1'b0;
        #1;
        chk("samecycle_swap_done", swap_done, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("samecycle_state", dbg_state, S_WAIT);
        repeat (3) begin
            @(negedge clk);
            chk("samecycle_no_swap", swap_done, 1'b0);
            chk("samecycle_pending", commit_pending, 1'b1);
            chk("samecycle_old_data", rd_data, 8'h1C);
        end
        vsync = 1'b1;
        @(negedge clk);
        do_swap(8'h1C, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            check_read(pal_tbl[i].addr, pal_tbl[i].exp);
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h00);
            note_err();
        end
        @(negedge clk);
        chk("sat_err_cnt", err_cnt, exp_err);
        chk("sat_err_cnt_max", err_cnt, 8'd255);

        // Reset in the middle of a write command
        send_byte(8'hA5);
        send_byte(8'h05);
        chk("midcmd_state", dbg_state, S_DATA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_err", err_cnt, 8'h00);
        chk("async_rst_state", dbg_state, S_IDLE);
        chk("async_rst_rd", rd_data, 8'h00);
        chk("async_rst_pending", commit_pending, 1'b0);
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_read(rst_tbl[i].addr, rst_tbl[i].exp);
        end
        send_byte(8'h01);
        note_err();
        @(negedge clk);
        chk("post_reset_err", err_cnt, exp_err);
        chk("post_reset_state", dbg_state, S_IDLE);
        chk("post_reset_swap", swap_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
